hilo_sequencer: RTL and testbench
=================================

HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set the cycles from mult/multu acceptance to HI/LO update.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set the cycles from div/divu acceptance to HI/LO update.
REQ-003 clk  in  1  SHALL be the clock; reset is synchronous, active-high; all state changes on posedge clk.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL flag a HILO-class request from the E stage.
REQ-006 req_op  in  4  SHALL carry the operation code from md_pkg: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-007 req_a, req_b  in  32 each  SHALL carry rs and rt operands.
REQ-008 flush  in  1  SHALL abandon any in-flight operation (exception or branch squash).
REQ-009 req_ready  out  1  SHALL be high when a request is accepted this cycle.
REQ-010 stall  out  1  SHALL request a pipeline freeze of D/E stages.
REQ-011 rd_data  out  32  SHALL return HI for MFHI, LO for MFLO, else 0.
REQ-012 busy  out  1  SHALL be high while an operation is in flight.

Function
REQ-013 States: IDLE and RUN; a 4-bit down-counter cnt is valid only in RUN.
REQ-014 Accept = req_valid & req_ready & !flush; req_ready = (state==IDLE).
REQ-015 MULT/MULTU/DIV/DIVU accepted in IDLE: latch operands and op, load cnt with MULT_CYCLES or DIV_CYCLES, enter RUN.
REQ-016 RUN: decrement cnt each cycle; at cnt==1, write HI/LO from latched result and return to IDLE on that edge.
REQ-017 Mult/div accepted at edge N: HI/LO SHALL hold new values from edge N+MULT_CYCLES (or N+DIV_CYCLES); busy high over edges N+1..N+latency-1.
REQ-018 MTHI/MTLO accepted in IDLE: HI (or LO) := req_a on the same edge; no RUN entry.
REQ-019 MFHI/MFLO: rd_data combinational from current HI/LO when accepted; no state change.
REQ-020 stall = req_valid & (req_op != NONE) & (state==RUN); stall SHALL be low in IDLE regardless of request.
REQ-021 MULT: signed 64-bit product {HI,LO}; MULTU: unsigned.
REQ-022 DIV: LO = signed quotient truncated toward zero, HI = remainder with dividend sign; DIVU: unsigned.
REQ-023 Divisor zero: HI and LO SHALL remain unchanged; the op still occupies full DIV_CYCLES.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-025 flush in RUN: return to IDLE next edge, HI/LO unchanged, no commit even if cnt==1 that cycle.
REQ-026 flush in IDLE with req_valid: request SHALL NOT be accepted; no HI/LO write.
REQ-027 Operands latched at acceptance; req_a/req_b changes during RUN SHALL NOT affect the result.

Reset
REQ-028 reset SHALL force state IDLE, cnt 0, HI 0, LO 0, busy 0, stall 0, rd_data 0 (when req_op NONE).
REQ-029 reset asserted during RUN SHALL discard the in-flight result; reset has priority over flush and requests.

Structure
REQ-030 md_pkg SHALL hold the op-code constants and default cycle counts, shared with the decoder.
REQ-031 One sub-module md_arith SHALL compute product/quotient/remainder combinationally from latched operands; sequencing stays in hilo_sequencer.

Verification
REQ-032 MULT a=0xFFFFFFFF, b=2 at edge 0 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE from edge 5; MULTU same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 DIV a=-7, b=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 -> HI/LO unchanged.
REQ-034 MULT then MFLO presented next cycle -> stall high 4 cycles, MFLO accepted in IDLE, rd_data = new LO.
REQ-035 DIV started, flush at cycle 9 -> IDLE next edge, HI/LO keep prior values, busy 0.
REQ-036 MTHI 0x12345678 then MFHI -> rd_data 0x12345678; reset mid-DIV -> HI=LO=0, busy 0.

Source files
------------

// File: rtl/md_pkg.sv
// Op codes, default latencies and result type shared by the HI/LO sequencer and the decoder.
// Pure definitions: no latency, no backpressure.
package md_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t OP_NONE  = 4'd0;
  localparam md_op_t OP_MULT  = 4'd1;
  localparam md_op_t OP_MULTU = 4'd2;
  localparam md_op_t OP_DIV   = 4'd3;
  localparam md_op_t OP_DIVU  = 4'd4;
  localparam md_op_t OP_MFHI  = 4'd5;
  localparam md_op_t OP_MFLO  = 4'd6;
  localparam md_op_t OP_MTHI  = 4'd7;
  localparam md_op_t OP_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_res_t;

  function automatic logic is_signed_op(input md_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_sequencer_if.sv
// E-stage to HI/LO sequencer request bus.
// Request held until req_ready; stall tells the pipeline to freeze D/E.
interface hilo_sequencer_if;

  logic           req_valid;
  md_pkg::md_op_t req_op;
  logic [31:0]    req_a;
  logic [31:0]    req_b;
  logic           flush;
  logic           req_ready;
  logic           stall;
  logic [31:0]    rd_data;
  logic           busy;

  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  req_ready, stall, rd_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output req_ready, stall, rd_data, busy
  );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide of latched operands into a {HI,LO} result.
// Zero latency; no handshake, wr drops for a zero divisor so HI/LO are left alone.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res
);

  logic        sgn;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    sgn   = is_signed_op(op);
    a_ext = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    // low 64 bits of the extended product are exact for both signednesses
    prod  = a_ext * b_ext;

    // divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
    a_mag = (sgn && a[31]) ? (32'd0 - a) : a;
    b_mag = (sgn && b[31]) ? (32'd0 - b) : b;
    q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;

    res = '0;
    case (op)
      OP_MULT, OP_MULTU: begin
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res.lo = (sgn && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
        res.hi = (sgn && a[31]) ? (32'd0 - r_mag) : r_mag;
        res.wr = (b != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hilo_sequencer.sv
// HI/LO register sequencer: mult/div commit MULT_CYCLES/DIV_CYCLES after accept, MT*/MF* act at once.
// One op in flight; req_ready low and stall raised for any request while RUN.
module hilo_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
  input  logic              clk,
  input  logic              reset,
  hilo_sequencer_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  cnt;
  md_op_t      op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        accept;
  md_res_t     res;

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready && !bus.flush;
  assign bus.busy      = (state == RUN);
  assign bus.stall     = bus.req_valid && (bus.req_op != OP_NONE) && (state == RUN);
  assign bus.rd_data   = (bus.req_op == OP_MFHI) ? hi :
                         (bus.req_op == OP_MFLO) ? lo : 32'd0;

  md_arith u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op_q  <= OP_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else if (state == RUN) begin
      // flush wins over the final-cycle commit
      if (bus.flush) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else if (cnt == 4'd1) begin
        state <= IDLE;
        cnt   <= 4'd0;
        if (res.wr) begin
          hi <= res.hi;
          lo <= res.lo;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else if (accept) begin
      case (bus.req_op)
        OP_MULT, OP_MULTU: begin
          op_q  <= bus.req_op;
          a_q   <= bus.req_a;
          b_q   <= bus.req_b;
          cnt   <= MULT_LD;
          state <= RUN;
        end
        OP_DIV, OP_DIVU: begin
          op_q  <= bus.req_op;
          a_q   <= bus.req_a;
          b_q   <= bus.req_b;
          cnt   <= DIV_LD;
          state <= RUN;
        end
        OP_MTHI: hi <= bus.req_a;
        OP_MTLO: lo <= bus.req_a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed scoreboard bench for hilo_sequencer: MF* reads are checked by a separate monitor.
// Latency, stall, flush and reset behaviour are checked inline.
module tb_hilo_sequencer;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_sequencer_if ifc();

  hilo_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted MFHI/MFLO must match the oldest expected value.
  always @(negedge clk) begin
    if (!reset && ifc.req_valid && ifc.req_ready && !ifc.flush &&
        (ifc.req_op == OP_MFHI || ifc.req_op == OP_MFLO)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_mf: got %h with no expected value queued", ifc.rd_data);
      end else begin
        chk("mf_rd_data", ifc.rd_data, exp_q.pop_front());
      end
    end
  end

  // Present a request and hold it until the sequencer takes it.
  task automatic drive(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    ifc.req_valid = 1'b1;
    ifc.req_op    = op;
    ifc.req_a     = a;
    ifc.req_b     = b;
    @(negedge clk);
    while (!ifc.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", 32'(ifc.req_ready), 32'd1);
    chk("stall_idle", 32'(ifc.stall), 32'd0);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_op    = OP_NONE;
  endtask

  task automatic mf(input md_op_t op, input logic [31:0] exp);
    exp_q.push_back(exp);
    drive(op, 32'd0, 32'd0);
  endtask

  // Count edges from acceptance until busy drops; HI/LO commit on that edge.
  task automatic wait_done(input string name, input int cycles);
    int n;
    n = 0;
    chk("busy_after_accept", 32'(ifc.busy), 32'd1);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ifc.busy && n < 40);
    chk(name, 32'(n), 32'(cycles));
  endtask

  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input string name, input int cycles);
    drive(op, a, b);
    wait_done(name, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    ifc.flush     = 1'b0;
    ifc.req_a     = 32'hDEAD_BEEF;
    ifc.req_b     = 32'd0;
    // request during reset must be ignored
    ifc.req_valid = 1'b1;
    ifc.req_op    = OP_MTHI;
    repeat (2) @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_op    = OP_NONE;
    @(negedge clk);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_stall", 32'(ifc.stall), 32'd0);
    chk("rst_ready", 32'(ifc.req_ready), 32'd1);
    chk("rst_rd_data", ifc.rd_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mf(OP_MFHI, 32'd0);
    mf(OP_MFLO, 32'd0);

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, "mult_latency", 5);
    mf(OP_MFHI, 32'hFFFF_FFFF);
    mf(OP_MFLO, 32'hFFFF_FFFE);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_latency", 5);
    mf(OP_MFHI, 32'h0000_0001);
    mf(OP_MFLO, 32'hFFFF_FFFE);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_latency", 10);
    mf(OP_MFHI, 32'hFFFF_FFFF);
    mf(OP_MFLO, 32'hFFFF_FFFD);

    run_op(OP_DIVU, 32'd7, 32'd0, "divu_zero_latency", 10);
    mf(OP_MFHI, 32'hFFFF_FFFF);
    mf(OP_MFLO, 32'hFFFF_FFFD);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf_latency", 10);
    mf(OP_MFHI, 32'h0000_0000);
    mf(OP_MFLO, 32'h8000_0000);

    // operands change while the op runs
    drive(OP_MULTU, 32'd3, 32'd5);
    ifc.req_a = 32'd9;
    ifc.req_b = 32'd11;
    wait_done("multu_latch_latency", 5);
    mf(OP_MFHI, 32'd0);
    mf(OP_MFLO, 32'd15);

    // MFLO right behind a MULT stalls, then reads the new LO
    drive(OP_MULT, 32'hFFFF_FFFD, 32'd4);
    exp_q.push_back(32'hFFFF_FFF4);
    ifc.req_valid = 1'b1;
    ifc.req_op    = OP_MFLO;
    @(negedge clk);
    chk("stall_in_run", 32'(ifc.stall), 32'd1);
    chk("ready_in_run", 32'(ifc.req_ready), 32'd0);
    drive(OP_MFLO, 32'd0, 32'd0);
    mf(OP_MFHI, 32'hFFFF_FFFF);

    drive(OP_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_no_run", 32'(ifc.busy), 32'd0);
    mf(OP_MFHI, 32'h1234_5678);
    drive(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    mf(OP_MFLO, 32'hCAFE_F00D);

    // flush in the final RUN cycle suppresses the commit
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_flush", 32'(ifc.busy), 32'd1);
    ifc.flush = 1'b1;
    @(posedge clk);
    #1;
    ifc.flush = 1'b0;
    chk("busy_after_flush", 32'(ifc.busy), 32'd0);
    mf(OP_MFHI, 32'h1234_5678);
    mf(OP_MFLO, 32'hCAFE_F00D);

    // flush in IDLE blocks acceptance
    ifc.req_valid = 1'b1;
    ifc.req_op    = OP_MTHI;
    ifc.req_a     = 32'hDEAD_BEEF;
    ifc.flush     = 1'b1;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_op    = OP_NONE;
    ifc.flush     = 1'b0;
    chk("idle_flush_busy", 32'(ifc.busy), 32'd0);
    mf(OP_MFHI, 32'h1234_5678);

    // reset mid-DIV, asserted together with flush
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b1;
    ifc.flush = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    ifc.flush = 1'b0;
    chk("reset_run_busy", 32'(ifc.busy), 32'd0);
    mf(OP_MFHI, 32'd0);
    mf(OP_MFLO, 32'd0);

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
